// File: rtl/fan_pkg.sv
// Shared types and constants for the fan ramp controller: FSM states, mode codes,
// the default top speed and the one-step speed helper.
package fan_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HOLD = 2'd1,
    ST_RAMP = 2'd2
  } fan_state_t;

  localparam logic [2:0] MODE_OFF = 3'd0;
  localparam logic [2:0] MODE_1   = 3'd1;
  localparam logic [2:0] MODE_2   = 3'd2;
  localparam logic [2:0] MODE_3   = 3'd3;

  localparam int SPEED_MAX_DEFAULT = 3;

  // Move one level toward the target; callers guarantee cur != tgt.
  function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
    return (tgt > cur) ? cur + 3'd1 : cur - 3'd1;
  endfunction

endpackage

// File: rtl/fan_ramp_ctrl_if.sv
// Mode-request handshake from the wall switch (A) and the remote (B).
// master = requester side, slave = fan controller side.
interface fan_ramp_ctrl_if;
  logic       req_a_valid;
  logic [2:0] req_a_mode;
  logic       req_a_ready;
  logic       req_b_valid;
  logic [2:0] req_b_mode;
  logic       req_b_ready;

  modport master (
    output req_a_valid, req_a_mode, req_b_valid, req_b_mode,
    input  req_a_ready, req_b_ready
  );

  modport slave (
    input  req_a_valid, req_a_mode, req_b_valid, req_b_mode,
    output req_a_ready, req_b_ready
  );
endinterface

// File: rtl/fan_rr_arb.sv
// Two-way round-robin arbiter: a grant is both the ready and the acceptance,
// and the requester not granted last wins a tie (A after reset).
module fan_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid_a,
  input  logic valid_b,
  output logic grant_a,
  output logic grant_b
);

  logic prefer_b_reg;

  assign grant_a = en && valid_a && (!valid_b || !prefer_b_reg);
  assign grant_b = en && valid_b && (!valid_a ||  prefer_b_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_b_reg <= 1'b0;
    end else if (grant_a) begin
      prefer_b_reg <= 1'b1;
    end else if (grant_b) begin
      prefer_b_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/fan_ramp_ctrl.sv
// Fan speed controller with two arbitrated mode requesters and power-loss cutoff.
// Define FAN_SOFT_START_EN to ramp one level per DWELL_CYCLES; otherwise speed jumps.
module fan_ramp_ctrl
  import fan_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int SPEED_MAX    = SPEED_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             elec,
  fan_ramp_ctrl_if.slave   req,
  output logic [2:0]       speed,
  output logic             busy,
  output logic             bad_req
);

  localparam logic [7:0] DWELL_LOAD  = 8'(DWELL_CYCLES - 1);
  localparam logic [2:0] SPEED_MAX_C = 3'(SPEED_MAX);

  fan_state_t state_reg, state_next;
  logic [2:0] speed_reg, speed_next;
  logic [2:0] target_reg, target_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       bad_req_reg, bad_req_next;

  logic       accept_en;
  logic       grant_a, grant_b;
  logic       accept;
  logic [2:0] acc_mode;
  logic       mode_ok;

  // Requests are refused while ramping or while the supply is missing.
  assign accept_en = elec && (state_reg != ST_RAMP);

  fan_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (accept_en),
    .valid_a (req.req_a_valid),
    .valid_b (req.req_b_valid),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign req.req_a_ready = grant_a;
  assign req.req_b_ready = grant_b;

  assign accept   = grant_a || grant_b;
  assign acc_mode = grant_a ? req.req_a_mode : req.req_b_mode;
  assign mode_ok  = (acc_mode <= SPEED_MAX_C);

  always_comb begin
    state_next   = state_reg;
    speed_next   = speed_reg;
    target_next  = target_reg;
    cnt_next     = cnt_reg;
    bad_req_next = 1'b0;

    if (!elec) begin
      state_next  = ST_OFF;
      speed_next  = MODE_OFF;
      target_next = MODE_OFF;
      cnt_next    = 8'd0;
    end else begin
      if (accept) begin
        if (!mode_ok) begin
          bad_req_next = 1'b1;
        end else if (acc_mode != target_reg) begin
          target_next = acc_mode;
          cnt_next    = DWELL_LOAD;
`ifdef FAN_SOFT_START_EN
          state_next  = ST_RAMP;
`else
          speed_next  = acc_mode;
          state_next  = (acc_mode == MODE_OFF) ? ST_OFF : ST_HOLD;
`endif
        end
      end
`ifdef FAN_SOFT_START_EN
      // Accept and ramp are exclusive: accept_en is low in RAMP.
      if (state_reg == ST_RAMP) begin
        if (cnt_reg == 8'd0) begin
          speed_next = step_toward(speed_reg, target_reg);
          cnt_next   = DWELL_LOAD;
          if (speed_next == target_reg) begin
            state_next = (target_reg == MODE_OFF) ? ST_OFF : ST_HOLD;
          end
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_OFF;
      speed_reg   <= MODE_OFF;
      target_reg  <= MODE_OFF;
      cnt_reg     <= 8'd0;
      bad_req_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      speed_reg   <= speed_next;
      target_reg  <= target_next;
      cnt_reg     <= cnt_next;
      bad_req_reg <= bad_req_next;
    end
  end

  assign speed   = speed_reg;
  assign bad_req = bad_req_reg;
`ifdef FAN_SOFT_START_EN
  assign busy    = (state_reg == ST_RAMP);
`else
  assign busy    = 1'b0;
`endif

endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// Directed bench for fan_ramp_ctrl; covers both builds, selected by FAN_SOFT_START_EN.
module tb_fan_ramp_ctrl;
  import fan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       elec = 1'b1;
  logic [2:0] speed;
  logic       busy;
  logic       bad_req;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cur;
  bit         busy_seen;

  always #5 clk = ~clk;

  fan_ramp_ctrl_if rq ();

  fan_ramp_ctrl #(.DWELL_CYCLES(8), .SPEED_MAX(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .elec    (elec),
    .req     (rq),
    .speed   (speed),
    .busy    (busy),
    .bad_req (bad_req)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present a request pair at a negedge, check readies, let one edge accept it.
  task automatic offer(input bit va, input logic [2:0] ma, input bit vb, input logic [2:0] mb,
                       input int exp_ra, input int exp_rb, input string tag);
    rq.req_a_valid = va;
    rq.req_a_mode  = ma;
    rq.req_b_valid = vb;
    rq.req_b_mode  = mb;
    #1;
    $display("txn %s: a(v=%0b m=%0d) b(v=%0b m=%0d) ready a=%0b b=%0b", tag, va, ma, vb, mb,
             rq.req_a_ready, rq.req_b_ready);
    chk({tag, "_ready_a"}, int'(rq.req_a_ready), exp_ra);
    chk({tag, "_ready_b"}, int'(rq.req_b_ready), exp_rb);
    @(negedge clk);
    rq.req_a_valid = 1'b0;
    rq.req_b_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    rq.req_a_valid = 1'b0;
    rq.req_a_mode  = 3'd0;
    rq.req_b_valid = 1'b0;
    rq.req_b_mode  = 3'd0;
    #1;
    chk("rst_speed",   int'(speed), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_bad_req", int'(bad_req), 0);
    chk("rst_state",   int'(dut.state_reg), int'(ST_OFF));
    chk("rst_target",  int'(dut.target_reg), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef FAN_SOFT_START_EN
    offer(1'b1, 3'd3, 1'b0, 3'd0, 1, 0, "a_m3");
    chk("ramp_busy_start", int'(busy), 1);
    chk("ramp_speed_start", int'(speed), 0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk($sformatf("ramp_speed_k%0d", k), int'(speed), k / 8);
      if (k == 23) chk("ramp_busy_k23", int'(busy), 1);
    end
    chk("ramp_busy_end", int'(busy), 0);
    chk("ramp_state_end", int'(dut.state_reg), int'(ST_HOLD));
    cur = 3;
`else
    offer(1'b1, 3'd2, 1'b0, 3'd0, 1, 0, "a_m2");
    chk("jump_speed", int'(speed), 2);
    chk("jump_state", int'(dut.state_reg), int'(ST_HOLD));
    busy_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      busy_seen = busy_seen | busy;
      @(negedge clk);
    end
    chk("jump_busy_never", int'(busy_seen), 0);
    cur = 2;
`endif

    // Same mode as target: accepted, nothing moves, and the pointer now favours A.
    offer(1'b0, 3'd0, 1'b1, 3'(cur), 0, 1, "b_same");
    chk("same_speed", int'(speed), cur);
    chk("same_target", int'(dut.target_reg), cur);
    chk("same_busy", int'(busy), 0);

    offer(1'b1, 3'd1, 1'b1, 3'd2, 1, 0, "both1");
    chk("both1_target", int'(dut.target_reg), 1);
`ifdef FAN_SOFT_START_EN
    chk("both1_busy", int'(busy), 1);
`endif
    wait_idle("both1");
    chk("both1_speed", int'(speed), 1);
    chk("both1_state", int'(dut.state_reg), int'(ST_HOLD));

    offer(1'b1, 3'd3, 1'b1, 3'd2, 0, 1, "both2");
    chk("both2_target", int'(dut.target_reg), 2);
    wait_idle("both2");
    chk("both2_speed", int'(speed), 2);

    offer(1'b0, 3'd0, 1'b1, 3'd6, 0, 1, "b_bad");
    chk("bad_pulse", int'(bad_req), 1);
    chk("bad_speed", int'(speed), 2);
    chk("bad_target", int'(dut.target_reg), 2);
    chk("bad_state", int'(dut.state_reg), int'(ST_HOLD));
    @(negedge clk);
    chk("bad_pulse_end", int'(bad_req), 0);

`ifdef FAN_SOFT_START_EN
    offer(1'b1, 3'd3, 1'b0, 3'd0, 1, 0, "a_m3_mid");
    repeat (3) @(negedge clk);
    chk("mid_speed", int'(speed), 2);
    chk("mid_busy", int'(busy), 1);
`endif
    rq.req_a_valid = 1'b1;
    rq.req_a_mode  = 3'd1;
    elec = 1'b0;
    #1;
    chk("pwr_ready_low", int'(rq.req_a_ready), 0);
    @(negedge clk);
    chk("pwr_speed", int'(speed), 0);
    chk("pwr_state", int'(dut.state_reg), int'(ST_OFF));
    chk("pwr_target", int'(dut.target_reg), 0);
    chk("pwr_busy", int'(busy), 0);
    chk("pwr_ready_held", int'(rq.req_a_ready), 0);
    repeat (3) @(negedge clk);
    chk("pwr_pending_ignored", int'(dut.target_reg), 0);
    rq.req_a_valid = 1'b0;
    elec = 1'b1;
    repeat (20) @(negedge clk);
    chk("pwr_back_speed", int'(speed), 0);
    chk("pwr_back_state", int'(dut.state_reg), int'(ST_OFF));

`ifdef FAN_SOFT_START_EN
    offer(1'b1, 3'd3, 1'b0, 3'd0, 1, 0, "a_m3_rst");
    repeat (8) @(negedge clk);
    chk("prerst_speed", int'(speed), 1);
    chk("prerst_busy", int'(busy), 1);
    repeat (2) @(negedge clk);
`else
    offer(1'b1, 3'd1, 1'b0, 3'd0, 1, 0, "a_m1_rst");
    chk("prerst_speed", int'(speed), 1);
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_mid_speed", int'(speed), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_state", int'(dut.state_reg), int'(ST_OFF));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_speed", int'(speed), 0);
    chk("post_rst_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
